// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32I MEM stage.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10
    } wb_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

endpackage

// File: rtl/rv32_load_align.sv
// Extracts the addressed byte/half/word from a load beat and sign- or zero-extends it.
module rv32_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/rv32_mem_stage.sv
// MEM stage: data-memory req/gnt/rvalid port, load alignment, stall, MEM/WB register and forwarding.
//   state   | meaning
//   IDLE    | no access outstanding; aligned memory op requests combinationally
//   REQ     | request presented, waiting for gnt
//   RESP    | load granted, waiting for rvalid
module rv32_mem_stage
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    input  logic        we_in,
    input  logic [1:0]  wb_src_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    mem_state_e  state, state_next;
    logic        mem_op;
    logic        misaligned;
    logic        done;
    logic [1:0]  ofs;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    assign ofs    = alu_in[1:0];
    assign mem_op = we_in | (wb_src_in == WB_MEM);

    // funct3[1:0] selects the access width; the reserved 11 encoding behaves as a byte
    always_comb begin
        misaligned = 1'b0;
        dmem_be    = 4'b0001 << ofs;
        dmem_wdata = {4{rs2_data_in[7:0]}};
        case (iw_in[13:12])
            2'b01: begin
                misaligned = ofs[0];
                dmem_be    = ofs[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{rs2_data_in[15:0]}};
            end
            2'b10: begin
                misaligned = (ofs != 2'b00);
                dmem_be    = 4'b1111;
                dmem_wdata = rs2_data_in;
            end
            default: ;
        endcase
        misaligned = misaligned & mem_op;
    end

    assign dmem_addr = {alu_in[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op && !misaligned) begin
                    dmem_req = 1'b1;
                    if (!dmem_gnt)  state_next = ST_REQ;
                    else if (we_in) done       = 1'b1;
                    else            state_next = ST_RESP;
                end
            end
            ST_REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (we_in) begin
                        done       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dmem_we   = dmem_req & we_in;
    assign mem_stall = mem_op & ~misaligned & ~done;

    rv32_load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (ofs),
        .funct3 (iw_in[14:12]),
        .data   (load_data)
    );

    always_comb begin
        case (wb_src_in)
            WB_MEM:  wb_data = load_data;
            WB_LINK: wb_data = pc_in + 32'd4;
            default: wb_data = alu_in;
        endcase
    end

    assign df_mem_enable = wb_enable_in & ~mem_stall & ~misaligned & (wb_reg_in != 5'd0);
    assign df_mem_reg    = wb_reg_in;
    assign df_mem_data   = wb_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out        <= '0;
            iw_out        <= '0;
            wb_data_out   <= '0;
            wb_reg_out    <= '0;
            wb_enable_out <= 1'b0;
            misalign_out  <= 1'b0;
        end else if (mem_stall || misaligned) begin
            pc_out        <= '0;
            iw_out        <= '0;
            wb_data_out   <= '0;
            wb_reg_out    <= '0;
            wb_enable_out <= 1'b0;
            misalign_out  <= misaligned;
        end else begin
            pc_out        <= pc_in;
            iw_out        <= iw_in;
            wb_data_out   <= wb_data;
            wb_reg_out    <= wb_reg_in;
            wb_enable_out <= wb_enable_in;
            misalign_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Randomized self-checking bench for rv32_mem_stage against an arithmetic reference model.
module tb_rv32_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in, we_in;
    logic [1:0]  wb_src_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall, misalign_out;
    logic [31:0] pc_out, iw_out, wb_data_out;
    logic [4:0]  wb_reg_out;
    logic        wb_enable_out;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32_mem_stage dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
        .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in), .we_in(we_in), .wb_src_in(wb_src_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign_out(misalign_out),
        .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
        .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_nop();
        pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0;
        wb_reg_in = '0; wb_enable_in = 1'b0; we_in = 1'b0; wb_src_in = 2'b00;
    endtask

    // Runs one instruction from its first MEM cycle to the edge that retires it.
    // d = cycles with gnt low before the grant, k = cycles from grant to rvalid (loads).
    // Entered and left at posedge+1.
    task automatic run_op(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic wen,
                          input logic we, input logic [1:0] src, input int d, input int k,
                          input logic [31:0] rdata_v);
        logic        memop, load, mis, signed_ld, exp_req, exp_stall, exp_df;
        int          sz, a, last;
        logic [31:0] v, exp_wb, exp_wdata;
        logic [3:0]  exp_be;
        memop     = we || (src == 2'b01);
        load      = memop && !we;
        a         = int'(alu[1:0]);
        sz        = (iw[13:12] == 2'b01) ? 2 : (iw[13:12] == 2'b10) ? 4 : 1;
        signed_ld = !iw[14];
        mis       = memop && ((a % sz) != 0);
        exp_be    = 4'(((1 << sz) - 1) << (a - (a % sz)));
        exp_wdata = (sz == 1) ? rs2[7:0] * 32'h01010101 :
                    (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
        last      = (!memop || mis) ? 0 : (we ? d : d + k);
        v = rdata_v >> (8 * a);
        if (sz == 1) begin
            v = v % 256;
            if (signed_ld && v >= 128) v = v - 256;
        end else if (sz == 2) begin
            v = v % 65536;
            if (signed_ld && v >= 32768) v = v - 65536;
        end
        exp_wb = (src == 2'b01) ? v : (src == 2'b10) ? pc + 4 : alu;

        pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
        wb_reg_in = rd; wb_enable_in = wen; we_in = we; wb_src_in = src;
        for (int c = 0; c <= last; c++) begin
            dmem_rdata = $urandom;
            if (memop && !mis) begin
                dmem_gnt    = (c < d) ? 1'b0 : (c == d) ? 1'b1 : 1'($urandom);
                dmem_rvalid = (c <= d) ? 1'($urandom) : (load && c == d + k);
                if (load && c == d + k) dmem_rdata = rdata_v;
            end else begin
                dmem_gnt    = 1'($urandom);
                dmem_rvalid = 1'($urandom);
            end
            @(negedge clk);
            exp_req   = memop && !mis && (c <= d);
            exp_stall = (c < last);
            exp_df    = (c == last) && wen && (rd != 5'd0) && !mis;
            check("dmem_req", 32'(dmem_req), 32'(exp_req));
            check("mem_stall", 32'(mem_stall), 32'(exp_stall));
            check("df_mem_enable", 32'(df_mem_enable), 32'(exp_df));
            if (exp_req) begin
                check("dmem_we", 32'(dmem_we), 32'(we));
                check("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
                check("dmem_be", 32'(dmem_be), 32'(exp_be));
                if (we) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (exp_df) begin
                check("df_mem_reg", 32'(df_mem_reg), 32'(rd));
                check("df_mem_data", df_mem_data, exp_wb);
            end
            @(posedge clk); #1;
            if (c < last) begin
                check("bubble_wb_enable", 32'(wb_enable_out), 32'd0);
                check("bubble_iw", iw_out, 32'd0);
            end else begin
                check("wb_enable_out", 32'(wb_enable_out), 32'(wen && !mis));
                check("misalign_out", 32'(misalign_out), 32'(mis));
                if (!mis) begin
                    check("wb_data_out", wb_data_out, exp_wb);
                    check("wb_reg_out", 32'(wb_reg_out), 32'(rd));
                    check("iw_out", iw_out, iw);
                    check("pc_out", pc_out, pc);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [1:0]  src;
        logic        we, wen;
        int          kind;
        logic [2:0]  ld_f3 [5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        reset = 1'b1;
        drive_nop();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #3;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_wb_enable", 32'(wb_enable_out), 32'd0);
        check("rst_wb_data", wb_data_out, 32'd0);
        check("rst_misalign", 32'(misalign_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD, SB, LB, LBU, misaligned LW, delayed SW
        run_op(32'h10, 32'h00000033, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 0, 1, 32'h0);
        run_op(32'h14, 32'h00000023, 32'h103, 32'hAB, 5'd0, 1'b0, 1'b1, 2'b00, 0, 1, 32'h0);
        run_op(32'h18, 32'h00000003, 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01, 0, 2, 32'h0080_0000);
        run_op(32'h1C, 32'h00004003, 32'h102, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 0, 2, 32'h0080_0000);
        run_op(32'h20, 32'h00002003, 32'h202, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 0, 1, 32'h0);
        run_op(32'h24, 32'h00002023, 32'h300, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 2'b00, 3, 1, 32'h0);

        // reset while a load waits in RESP, then a late rvalid
        alu_in = 32'h100; iw_in = 32'h00002003; wb_src_in = 2'b01; we_in = 1'b0;
        wb_enable_in = 1'b1; wb_reg_in = 5'd9; dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        #2;
        reset = 1'b1;
        drive_nop();
        #1;
        check("midrst_dmem_req", 32'(dmem_req), 32'd0);
        check("midrst_mem_stall", 32'(mem_stall), 32'd0);
        check("midrst_wb_enable", 32'(wb_enable_out), 32'd0);
        check("midrst_iw_out", iw_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("late_rvalid_wb_enable", 32'(wb_enable_out), 32'd0);
        check("late_rvalid_wb_data", wb_data_out, 32'd0);
        run_op(32'hFFFFFFFC, 32'h0000006F, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 0, 1, 32'h0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            we   = 1'b0;
            src  = 2'b00;
            f3   = 3'($urandom);
            wen  = 1'($urandom);
            case (kind)
                0: src = 2'($urandom_range(0, 1) * 3);
                1: begin src = 2'b01; f3 = ld_f3[$urandom_range(0, 4)]; end
                2: begin we = 1'b1; f3 = 3'($urandom_range(0, 2)); end
                default: src = 2'b10;
            endcase
            run_op($urandom, {$urandom} & 32'hFFFF8FFF | {17'h0, f3, 12'h0}, $urandom, $urandom,
                   5'($urandom), wen, we, src, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
